// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage issue control tracking pending load results and the single CFU op.
// Latency: stall/flush/issue are combinational from registered state and the ID/EX inputs; state updates on the next edge.
// Backpressure: stall holds PC and IF/ID and bubbles EX; flush overrides stall and never records the squashed instruction.
module id_scoreboard #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter logic [1:0]  WB_LOAD      = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd,
    input  logic       id_rf_en,
    input  logic [1:0] id_wb_sel,
    input  logic       id_long,
    input  logic       long_done,
    input  logic       ex_flush,
    output logic       issue_o,
    output logic       stall_o,
    output logic       flush_o,
    output logic       long_busy_o
);

    // Decode-stage hazard controls handed to the ID/EX pipeline register.
    typedef struct packed {
        logic stall;
        logic flush;
    } id_hdu_out_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Bubble count loaded for a load destination; legal values are 1..3.
    localparam logic [1:0] LOAD_CNT = LOAD_BUBBLES[1:0];

    // Per-register bubble counters; x0 has no storage and always reads as zero.
    logic [1:0]        cnt_q [1:31];
    logic [31:0][1:0]  cnt_vec;

    logic [0:0]  state_q;
    logic [4:0]  long_rd_q;

    logic        busy;
    logic        hz_s1;
    logic        hz_s2;
    logic        hz_s;
    logic        hz_l;
    logic        issue;
    logic        rec_wr;
    logic [1:0]  rec_val;
    id_hdu_out_t hdu;

    assign busy = (state_q == ST_BUSY);

    // Flatten the counters into an indexable vector with a hardwired zero for x0.
    always_comb begin
        cnt_vec    = '0;
        cnt_vec[0] = 2'b00;
        for (int r = 1; r < 32; r++) begin
            cnt_vec[r] = cnt_q[r];
        end
    end

    // Source hazards: a used, non-zero source whose producer is not yet forwardable.
    always_comb begin
        hz_s1 = id_rs1_used && (id_rs1 != 5'd0) && (cnt_vec[id_rs1] != 2'b00);
        hz_s2 = id_rs2_used && (id_rs2 != 5'd0) && (cnt_vec[id_rs2] != 2'b00);
        hz_s  = hz_s1 || hz_s2;
    end

    // Long-op hazard: RAW or WAW against the CFU destination, or a second CFU op while one is in flight.
    always_comb begin
        hz_l = busy && ((id_rs1_used && (id_rs1 == long_rd_q)) ||
                        (id_rs2_used && (id_rs2 == long_rd_q)) ||
                        (id_rf_en    && (id_rd  == long_rd_q)) ||
                        id_long);
    end

    // Output controls; flush wins over stall, and only an unstalled, unflushed instruction issues.
    always_comb begin
        hdu.flush = ex_flush;
        hdu.stall = id_valid && !ex_flush && (hz_s || hz_l);
        issue     = id_valid && !hdu.stall && !ex_flush;
    end

    assign stall_o     = hdu.stall;
    assign flush_o     = hdu.flush;
    assign issue_o     = issue;
    assign long_busy_o = busy;

    // Value recorded for the issuing destination: loads wait, everything else is forwardable at once.
    always_comb begin
        rec_wr  = issue && id_rf_en && (id_rd != 5'd0);
        rec_val = (id_wb_sel == WB_LOAD) ? LOAD_CNT : 2'b00;
    end

    // Each counter ages by one per cycle; a new issue to the same register overrides the ageing.
    for (genvar r = 1; r < 32; r++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[r] <= 2'b00;
            end else if (rec_wr && (id_rd == 5'(r))) begin
                cnt_q[r] <= rec_val;
            end else if (cnt_q[r] != 2'b00) begin
                cnt_q[r] <= cnt_q[r] - 2'b01;
            end
        end
    end

    // CFU tracker: enter BUSY when a long op issues, leave on its completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            long_rd_q <= 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && id_long) begin
                        state_q   <= ST_BUSY;
                        long_rd_q <= id_rf_en ? id_rd : 5'd0;
                    end
                end
                ST_BUSY: begin
                    if (long_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed vectors for id_scoreboard with a queued scoreboard.
// Latency: expected {issue,stall,flush,busy} is queued per driven cycle and checked at the falling edge.
// Backpressure: none; the bench drives one ID instruction per cycle.
module tb_id_scoreboard;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_LD  = 2'b01;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rf_en;
    logic [1:0] id_wb_sel;
    logic       id_long;
    logic       long_done;
    logic       ex_flush;
    logic       issue_o;
    logic       stall_o;
    logic       flush_o;
    logic       long_busy_o;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q  [$];
    string      name_q [$];

    id_scoreboard #(.LOAD_BUBBLES(1), .WB_LOAD(2'b01)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rf_en    (id_rf_en),
        .id_wb_sel   (id_wb_sel),
        .id_long     (id_long),
        .long_done   (long_done),
        .ex_flush    (ex_flush),
        .issue_o     (issue_o),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .long_busy_o (long_busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: whenever an expectation is pending, compare the outputs mid-cycle.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] got;
        string      n;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got = {issue_o, stall_o, flush_o, long_busy_o};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: issue/stall/flush/busy got %b expected %b", n, got, e);
            end
        end
    end

    task automatic quiet();
        id_valid    = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_rd       = 5'd0;
        id_rf_en    = 1'b0;
        id_wb_sel   = WB_ALU;
        id_long     = 1'b0;
        long_done   = 1'b0;
        ex_flush    = 1'b0;
    endtask

    // Present one instruction in ID (unused sources passed as index 0).
    task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rf_en, input logic [1:0] wb, input logic lng);
        quiet();
        id_valid    = 1'b1;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = (rs1 != 5'd0);
        id_rs2_used = (rs2 != 5'd0);
        id_rd       = rd;
        id_rf_en    = rf_en;
        id_wb_sel   = wb;
        id_long     = lng;
    endtask

    // Queue the expected outputs for the current inputs, then advance one cycle.
    task automatic chk(input logic ei, input logic es, input logic ef, input logic eb, input string name);
        exp_q.push_back({ei, es, ef, eb});
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        @(posedge clk);
        #1;
        chk(0, 0, 0, 0, "reset_quiet");
        rst = 1'b0;

        // Load-use with one bubble.
        ins(5'd1, 5'd0, 5'd5, 1, WB_LD, 0);   chk(1, 0, 0, 0, "lw_x5_issue");
        ins(5'd5, 5'd1, 5'd6, 1, WB_ALU, 0);  chk(0, 1, 0, 0, "load_use_stall");
        ins(5'd5, 5'd1, 5'd6, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "load_use_issue");
        ins(5'd0, 5'd5, 5'd2, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "x5_counter_clear");

        // ALU producer and load to x0 never stall consumers.
        ins(5'd1, 5'd0, 5'd7, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "alu_x7_issue");
        ins(5'd7, 5'd7, 5'd3, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "alu_x7_consumer");
        ins(5'd1, 5'd0, 5'd0, 1, WB_LD, 0);   chk(1, 0, 0, 0, "lw_x0_issue");
        id_valid = 1; id_rs1 = 5'd0; id_rs1_used = 1; id_rd = 5'd3; id_wb_sel = WB_ALU;
        chk(1, 0, 0, 0, "x0_consumer");

        // Long op to x9.
        ins(5'd2, 5'd0, 5'd9, 1, WB_ALU, 1);  chk(1, 0, 0, 0, "long_x9_issue");
        ins(5'd9, 5'd0, 5'd4, 1, WB_ALU, 0);  chk(0, 1, 0, 1, "long_dep_stall_a");
        ins(5'd0, 5'd9, 5'd4, 1, WB_ALU, 0);  chk(0, 1, 0, 1, "long_dep_stall_b");
        ins(5'd3, 5'd0, 5'd10, 1, WB_ALU, 0); chk(1, 0, 0, 1, "busy_independent");
        ins(5'd3, 5'd0, 5'd11, 1, WB_ALU, 1); chk(0, 1, 0, 1, "second_long_stall");
        ins(5'd3, 5'd0, 5'd9, 1, WB_ALU, 0);  chk(0, 1, 0, 1, "long_waw_stall");
        ins(5'd9, 5'd0, 5'd4, 1, WB_ALU, 0); long_done = 1;
        chk(0, 1, 0, 1, "dep_on_done_cycle");
        ins(5'd9, 5'd0, 5'd4, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "dep_after_done");

        // Back-to-back long ops around a completion pulse.
        ins(5'd1, 5'd0, 5'd12, 1, WB_ALU, 1); chk(1, 0, 0, 0, "long_x12_issue");
        ins(5'd1, 5'd0, 5'd13, 1, WB_ALU, 1); long_done = 1;
        chk(0, 1, 0, 1, "done_vs_new_long");
        ins(5'd1, 5'd0, 5'd13, 1, WB_ALU, 1); chk(1, 0, 0, 0, "new_long_after_done");
        quiet(); long_done = 1;                chk(0, 0, 0, 1, "done_quiet");
        quiet(); long_done = 1;                chk(0, 0, 0, 0, "done_in_idle_ignored");
        ins(5'd1, 5'd0, 5'd14, 0, WB_ALU, 1); chk(1, 0, 0, 0, "long_no_rd_issue");
        ins(5'd1, 5'd0, 5'd14, 1, WB_ALU, 1); chk(0, 1, 0, 1, "long_rd0_blocks");
        quiet(); long_done = 1;                chk(0, 0, 0, 1, "long_rd0_done");

        // Flush beats a load-use hazard; counters of older loads persist.
        ins(5'd1, 5'd0, 5'd4, 1, WB_LD, 0);   chk(1, 0, 0, 0, "lw_x4_issue");
        ins(5'd4, 5'd0, 5'd5, 1, WB_ALU, 0); ex_flush = 1;
        chk(0, 0, 1, 0, "flush_over_stall");
        ins(5'd4, 5'd0, 5'd5, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "x4_expired");
        ins(5'd1, 5'd0, 5'd14, 1, WB_LD, 0); ex_flush = 1;
        chk(0, 0, 1, 0, "flushed_load");
        ins(5'd14, 5'd0, 5'd5, 1, WB_ALU, 0); chk(1, 0, 0, 0, "flushed_not_recorded");
        ins(5'd1, 5'd0, 5'd20, 1, WB_ALU, 1); chk(1, 0, 0, 0, "long_x20_issue");
        ins(5'd20, 5'd0, 5'd5, 1, WB_ALU, 0); ex_flush = 1;
        chk(0, 0, 1, 1, "flush_keeps_busy");
        ins(5'd20, 5'd0, 5'd5, 1, WB_ALU, 0); chk(0, 1, 0, 1, "busy_after_flush");
        quiet(); long_done = 1;                chk(0, 0, 0, 1, "x20_done");

        // Load then ALU overwrite of x8.
        ins(5'd1, 5'd0, 5'd8, 1, WB_LD, 0);   chk(1, 0, 0, 0, "lw_x8_issue");
        ins(5'd1, 5'd0, 5'd8, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "alu_x8_overwrite");
        ins(5'd8, 5'd8, 5'd3, 1, WB_ALU, 0);  chk(1, 0, 0, 0, "x8_consumer");

        // Reset while busy with a live load counter.
        ins(5'd1, 5'd0, 5'd15, 1, WB_ALU, 1); chk(1, 0, 0, 0, "long_x15_issue");
        ins(5'd1, 5'd0, 5'd16, 1, WB_LD, 0);  chk(1, 0, 0, 1, "lw_x16_busy");
        ins(5'd15, 5'd16, 5'd3, 1, WB_ALU, 0); chk(0, 1, 0, 1, "pre_reset_stall");
        ins(5'd15, 5'd16, 5'd3, 1, WB_ALU, 0); rst = 1;
        chk(1, 0, 0, 0, "async_reset_clears");
        rst = 0;
        ins(5'd15, 5'd16, 5'd3, 1, WB_ALU, 1); chk(1, 0, 0, 0, "post_reset_issue");
        quiet(); long_done = 1;                 chk(0, 0, 0, 1, "post_reset_long_busy");
        quiet(); long_done = 1;                 chk(0, 0, 0, 0, "spurious_done");

        quiet();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
